fac_4_dec: RTL and testbench

FAC_4_DEC -- requirements
Module: fac_4_dec

---
 rtl/fac_4_dec.sv | 95 +++++++++
 tb/tb_fac_4_dec.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fac_4_dec.sv
// rtl/fac_4_dec.sv - two-stage elastic decoder recovering a nibble from its 9-bit factor bundle
// Optional saturating bad-bundle counter enabled by FAC_4_DEC_ERRCNT_EN.
module fac_4_dec (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] in_q,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_a,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       clr_err,
    output logic       err_sticky,
    output logic [7:0] err_cnt
);

    logic [8:0] s1_q;
    logic       s1_valid;
    logic       s1_err;
    logic       s2_valid;
    logic       advance;
    logic       s1_open;
    logic       err_event;

    // Re-derive every parity/sum field from the raw bundle; any disagreement flags it.
    assign s1_err = (s1_q[2]   != (s1_q[1] ^ s1_q[0]))
                  | (s1_q[5]   != (s1_q[4] ^ s1_q[3]))
                  | (s1_q[7:6] != (s1_q[4:3] ^ s1_q[1:0]))
                  | (s1_q[8]   != (s1_q[7] ^ s1_q[6]));

    assign advance   = !s2_valid | out_ready;
    assign s1_open   = !s1_valid | advance;
    assign err_event = advance & s1_valid & s1_err;

    // Reset masks the handshakes so nothing transfers during the reset cycle.
    assign in_ready  = s1_open & !rst;
    assign out_valid = s2_valid & !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= 9'd0;
        end else if (s1_open) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= in_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_a    <= 4'd0;
            out_err  <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_a   <= {s1_q[4:3], s1_q[1:0]};
                out_err <= s1_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (err_event) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

`ifdef FAC_4_DEC_ERRCNT_EN
    // A coinciding clear restarts the count at the new event rather than dropping it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (err_event) begin
            if (clr_err) begin
                err_cnt <= 8'd1;
            end else if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end else if (clr_err) begin
            err_cnt <= 8'd0;
        end
    end
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_fac_4_dec.sv
// tb/tb_fac_4_dec.sv - randomized self-checking bench for fac_4_dec against a queue-based model
module tb_fac_4_dec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] in_q = 9'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_a;
    logic       out_err;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic       err_sticky;
    logic [7:0] err_cnt;

    fac_4_dec dut (
        .clk(clk),
        .rst(rst),
        .in_q(in_q),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_a(out_a),
        .out_err(out_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .clr_err(clr_err),
        .err_sticky(err_sticky),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] q;
        bit         shown;
    } item_t;

    item_t mq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    m_sticky = 0;
    int    m_cnt = 0;

    function automatic logic [8:0] enc(input logic [3:0] a);
        logic [1:0] sa;
        sa = a[3:2] ^ a[1:0];
        return {^sa, sa, ^a[3:2], a[3:2], ^a[1:0], a[1:0]};
    endfunction

    function automatic logic [3:0] dec(input logic [8:0] q);
        return {q[4], q[3], q[1], q[0]};
    endfunction

    function automatic bit is_bad(input logic [8:0] q);
        return q != enc(dec(q));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic iv, input logic [8:0] q, input logic ordy,
                       input logic clr, input logic r);
        bit    exp_ov, exp_ir, acc, otx, ev;
        item_t h;
        int    exp_cnt;
        @(negedge clk);
        rst = r; in_valid = iv; in_q = q; out_ready = ordy; clr_err = clr;
        #1;
        exp_ov = !r && mq.size() > 0 && mq[0].shown;
        exp_ir = !(mq.size() == 2 && !ordy);
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (!r) begin
            check("in_ready", 32'(in_ready), 32'(exp_ir));
            if (exp_ov) begin
                check("out_a", 32'(out_a), 32'(dec(mq[0].q)));
                check("out_err", 32'(out_err), 32'(is_bad(mq[0].q)));
            end
            check("err_sticky", 32'(err_sticky), 32'(m_sticky));
`ifdef FAC_4_DEC_ERRCNT_EN
            exp_cnt = m_cnt;
`else
            exp_cnt = 0;
`endif
            check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
        end
        acc = !r && iv && exp_ir;
        otx = exp_ov && ordy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_sticky = 0;
            m_cnt = 0;
        end else begin
            if (otx) void'(mq.pop_front());
            ev = 0;
            if (mq.size() > 0 && !mq[0].shown) begin
                h = mq[0];
                h.shown = 1;
                mq[0] = h;
                ev = is_bad(h.q);
            end
            if (ev) begin
                m_sticky = 1;
                m_cnt = clr ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
            end else if (clr) begin
                m_sticky = 0;
                m_cnt = 0;
            end
            if (acc) begin
                h.q = q;
                h.shown = 0;
                mq.push_back(h);
            end
        end
    endtask

    function automatic logic [8:0] bad_bundle();
        logic [8:0] flip;
        flip = 9'd1 << $urandom_range(8, 0);
        return enc(4'($urandom)) ^ flip;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) cyc(0, 9'd0, 0, 0, 1);
        cyc(0, 9'd0, 1, 0, 0);

        cyc(1, 9'b1_10_1_10_0_10, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 9'd0, 1, 0, 0);

        for (int n = 0; n < 16; n++) cyc(1, enc(4'(n)), 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 9'd0, 1, 0, 0);

        cyc(1, enc(4'h5) ^ 9'h100, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 9'd0, 1, 0, 0);
        cyc(0, 9'd0, 1, 1, 0);

        for (int i = 0; i < 5; i++) cyc(1, enc(4'(i + 3)), 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 9'd0, 1, 0, 0);

        for (int i = 0; i < 300; i++) cyc(1, bad_bundle(), 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 9'd0, 1, 0, 0);
        cyc(1, enc(4'h9) ^ 9'h004, 1, 0, 0);
        cyc(0, 9'd0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 9'd0, 1, 0, 0);

        for (int i = 0; i < 3; i++) cyc(1, enc(4'(i + 7)), 0, 0, 0);
        cyc(1, enc(4'hC), 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 9'd0, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [8:0] q;
            q = ($urandom_range(9, 0) < 7) ? enc(4'($urandom)) : 9'($urandom);
            cyc(1'($urandom_range(3, 0) != 0), q, 1'($urandom_range(2, 0) != 0),
                1'($urandom_range(19, 0) == 0), 1'($urandom_range(199, 0) == 0));
        end
        for (int i = 0; i < 4; i++) cyc(0, 9'd0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
